adc_scan_sequencer: RTL and testbench
=====================================

# adc_scan_sequencer

Scans a programmable set of AVR ADC channels round-robin: drives the channel select toward the AVR sample link, waits for matching samples, and discards the settling samples after each channel switch. Stores the latest 10-bit result per channel in a 16-entry table with a registered read port. Sits between the AVR interface's sample outputs (`channel`, `new_sample`, `sample`, `sample_channel`) and application logic. Replaces hand-driven channel selection.

## Interface
Parameters:
- `DISCARD`, 1: matching samples dropped after each channel switch (0..3).
- `TIMEOUT`, 50000: cycles to wait for a kept sample before skipping the channel; must be < 2^`CTR_SIZE`.
- `CTR_SIZE`, 16: timeout counter width.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `channel_mask` in 16: bit i enables channel i; latched at each scan start.
- `start` in 1: begin a scan when idle; ignored while `busy`.
- `continuous` in 1: when high at scan end, begin the next scan immediately.
- `channel` out 4: channel request to the AVR interface.
- `new_sample` in 1: one-cycle strobe, sample available.
- `sample` in 10: sample value.
- `sample_channel` in 4: channel the sample belongs to.
- `rd_channel` in 4: table read address.
- `rd_sample` out 10: table data, one cycle after address.
- `rd_valid` out 1: entry written since reset, one cycle after address.
- `busy` out 1: scan in progress.
- `scan_done` out 1: one-cycle pulse at end of each scan.
- `timeout_err` out 1: sticky; set on any channel timeout, cleared only by `rst` or by `start` accepted in IDLE.

## Operation
- States: IDLE, SELECT, WAIT, STORE.
- IDLE: `busy`=0. On `start`, latch `mask_q`=`channel_mask`, clear `timeout_err`, set `last`=15, go to SELECT.
- SELECT: `next` = first set bit of `mask_q` searching `last`+1, `last`+2, … modulo 16 with wrap-around. Bits already serviced this scan are cleared from a `pending` copy of `mask_q`.
  - If `pending`=0: pulse `scan_done`. If `continuous`=1, relatch the mask, reload `pending`, stay in SELECT; else go to IDLE.
  - Otherwise: register `channel`=`next`, `last`=`next`, load `discard_ct`=`DISCARD`, clear the timeout counter, go to WAIT.
- WAIT: the timeout counter increments every cycle.
  - On `new_sample` with `sample_channel`==`channel`: if `discard_ct`>0, decrement it; else capture `sample` and go to STORE.
  - `new_sample` for any other channel is stale (pipeline lag after the switch) and is ignored without counting.
  - When the counter reaches `TIMEOUT`-1 with no capture: set `timeout_err`, clear the `pending` bit, go to SELECT. The table entry is unchanged.
  - A kept sample arriving in the same cycle the timeout expires wins: it is captured and no error is raised.
- STORE: write the table entry for `channel`, set its valid bit, clear its `pending` bit, go to SELECT.
- Empty mask at start: the scan completes with zero channels (`scan_done` pulse, no table writes).
- Table: 16×10 storage plus 16 valid bits. Read is registered and independent of scan state. A read and a write to the same entry in the same cycle returns the old data and old valid bit.
- `rst` at any time aborts the scan. All state returns to reset values in the next cycle; valid bits are cleared, and data contents need not be cleared.

## Timing
- Reset values: `channel`=0, `busy`=0, `scan_done`=0, `timeout_err`=0, `rd_sample`=0, `rd_valid`=0, state IDLE.
- `start` sampled high at edge N (IDLE):
  - `busy`=1 from N+1.
  - SELECT during N+1.
  - `channel` shows the first enabled channel from N+2.
- `busy` stays 1 through the SELECT cycle that pulses `scan_done`. It drops the next cycle unless continuous.
- Channel-switch overhead: 2 cycles (STORE + SELECT) between a captured sample and the next `channel` update.
- Per channel: a capture requires `DISCARD`+1 matching strobes.
- Timeout: exactly `TIMEOUT` cycles in WAIT, measured from the cycle `channel` updates.
- Read latency: 1 cycle.
- `scan_done` width: exactly 1 cycle per scan, including empty scans.

## Test plan
- Mask 16'h0005, DISCARD=1, model returns ch0=0x155 and ch2=0x2AA. Required: `channel` 0 then 2; the first matching strobe per channel is dropped; one `scan_done`; reads give ch0 0x155/valid, ch2 0x2AA/valid, ch1 valid=0.
- Wrap-around: mask 16'h8001, `continuous`=1. Required: `channel` sequence 0, 15, 0, 15 and one `scan_done` per pair.
- Stale samples: after switching to ch3, inject strobes tagged ch1. Required: ignored, ch1 entry unchanged, ch3 captured only from ch3 strobes.
- Timeout: TIMEOUT=20, mask 16'h0003, no strobes for ch0. Required: after 20 cycles `timeout_err`=1, `channel` moves to 1, ch0 `rd_valid`=0; a kept sample arriving on the expiry cycle captures with no error.
- Mask 0 with `start`. Required: `scan_done` pulse 2 cycles after `start`, no writes, `busy` back to 0.
- `rst` during WAIT. Required: next cycle `busy`=0, `channel`=0, all `rd_valid`=0; `start` while `busy` is ignored.

Source files
------------

// File: rtl/adc_scan_sequencer_if.sv
// Signal bundle between adc_scan_sequencer and its surroundings.
// Purpose: groups the scan control, AVR sample link and table read port so that one modport
// connects the sequencer (slave) and one connects the application / AVR side (master).
// Signals:
//   channel_mask   16  channel enables, bit i enables channel i
//   start           1  begin a scan when idle
//   continuous      1  rescan immediately at scan end
//   channel         4  channel request toward the AVR interface
//   new_sample      1  one-cycle strobe, sample available
//   sample         10  sample value
//   sample_channel  4  channel the sample belongs to
//   rd_channel      4  table read address
//   rd_sample      10  table data, one cycle after address
//   rd_valid        1  entry written since reset, one cycle after address
//   busy            1  scan in progress
//   scan_done       1  one-cycle pulse at end of each scan
//   timeout_err     1  sticky channel timeout flag
interface adc_scan_sequencer_if;
    logic [15:0] channel_mask;
    logic        start;
    logic        continuous;
    logic [3:0]  channel;
    logic        new_sample;
    logic [9:0]  sample;
    logic [3:0]  sample_channel;
    logic [3:0]  rd_channel;
    logic [9:0]  rd_sample;
    logic        rd_valid;
    logic        busy;
    logic        scan_done;
    logic        timeout_err;

    modport master (
        output channel_mask, start, continuous, new_sample, sample, sample_channel, rd_channel,
        input  channel, rd_sample, rd_valid, busy, scan_done, timeout_err
    );

    modport slave (
        input  channel_mask, start, continuous, new_sample, sample, sample_channel, rd_channel,
        output channel, rd_sample, rd_valid, busy, scan_done, timeout_err
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Round-robin AVR ADC channel scanner with a per-channel result table.
// Purpose: steps the AVR channel request through the enabled channels, drops the settling
// samples after each switch, keeps the next matching sample and stores it in a 16-entry
// table (10-bit data + valid bit) that has a registered read port.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  adc_scan_sequencer_if.slave: scan control, AVR sample link, table read port
module adc_scan_sequencer #(
    parameter int unsigned DISCARD  = 1,
    parameter int unsigned TIMEOUT  = 50000,
    parameter int unsigned CTR_SIZE = 16
) (
    input logic                 clk,
    input logic                 rst,
    adc_scan_sequencer_if.slave bus
);

    localparam logic [CTR_SIZE-1:0] CtrLast     = CTR_SIZE'(TIMEOUT - 1);
    localparam logic [1:0]          DiscardInit = 2'(DISCARD);

    typedef enum logic [1:0] {StIdle, StSelect, StWait, StStore} state_e;

    state_e              state_q, state_d;
    logic [15:0]         pending_q, pending_d;
    logic [3:0]          last_q, last_d;
    logic [3:0]          channel_q, channel_d;
    logic [1:0]          discard_q, discard_d;
    logic [CTR_SIZE-1:0] ctr_q, ctr_d;
    logic [9:0]          capture_q, capture_d;
    logic                scan_done_q, scan_done_d;
    logic                timeout_err_q, timeout_err_d;

    logic [9:0]          table_q [16];
    logic [15:0]         valid_q;
    logic [9:0]          rd_sample_q;
    logic                rd_valid_q;
    logic                wr_en;

    logic [3:0]          next_ch;
    logic                sample_match;

    // First pending channel after last_q, wrapping; i == 16 lands back on last_q itself.
    always_comb begin
        logic       found;
        logic [3:0] idx;
        found   = 1'b0;
        next_ch = 4'd0;
        idx     = 4'd0;
        for (int i = 1; i <= 16; i++) begin
            idx = last_q + 4'(i);
            if (!found && pending_q[idx]) begin
                found   = 1'b1;
                next_ch = idx;
            end
        end
    end

    // Samples tagged with another channel are pipeline leftovers from before the switch.
    assign sample_match = bus.new_sample && (bus.sample_channel == channel_q);

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        last_d        = last_q;
        channel_d     = channel_q;
        discard_d     = discard_q;
        ctr_d         = ctr_q;
        capture_d     = capture_q;
        scan_done_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        wr_en         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    pending_d     = bus.channel_mask;
                    timeout_err_d = 1'b0;
                    last_d        = 4'hf;
                    state_d       = StSelect;
                end
            end
            StSelect: begin
                if (pending_q == 16'h0000) begin
                    scan_done_d = 1'b1;
                    if (bus.continuous) begin
                        pending_d = bus.channel_mask;
                        last_d    = 4'hf;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    channel_d = next_ch;
                    last_d    = next_ch;
                    discard_d = DiscardInit;
                    ctr_d     = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                ctr_d = ctr_q + CTR_SIZE'(1);
                if (sample_match && discard_q != 2'd0) begin
                    discard_d = discard_q - 2'd1;
                end
                // A kept sample on the expiry cycle takes priority over the timeout.
                if (sample_match && discard_q == 2'd0) begin
                    capture_d = bus.sample;
                    state_d   = StStore;
                end else if (ctr_q == CtrLast) begin
                    timeout_err_d        = 1'b1;
                    pending_d[channel_q] = 1'b0;
                    state_d              = StSelect;
                end
            end
            StStore: begin
                wr_en                = 1'b1;
                pending_d[channel_q] = 1'b0;
                state_d              = StSelect;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pending_q     <= '0;
            last_q        <= 4'hf;
            channel_q     <= '0;
            discard_q     <= '0;
            ctr_q         <= '0;
            capture_q     <= '0;
            scan_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            valid_q       <= '0;
            rd_sample_q   <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            last_q        <= last_d;
            channel_q     <= channel_d;
            discard_q     <= discard_d;
            ctr_q         <= ctr_d;
            capture_q     <= capture_d;
            scan_done_q   <= scan_done_d;
            timeout_err_q <= timeout_err_d;
            // Read sees the table before this cycle's write (old data on collision).
            rd_sample_q   <= table_q[bus.rd_channel];
            rd_valid_q    <= valid_q[bus.rd_channel];
            if (wr_en) begin
                valid_q[channel_q] <= 1'b1;
            end
        end
    end

    // Data storage is not reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            table_q[channel_q] <= capture_q;
        end
    end

    assign bus.channel     = channel_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.scan_done   = scan_done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.rd_sample   = rd_sample_q;
    assign bus.rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a result-table model and per-cycle read checks.
module tb_adc_scan_sequencer;
    localparam int unsigned Discard = 1;
    localparam int unsigned Timeout = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adc_scan_sequencer_if bus ();

    adc_scan_sequencer #(
        .DISCARD  (Discard),
        .TIMEOUT  (Timeout),
        .CTR_SIZE (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; after edge k this reads k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] rd_addr_q;
    always @(posedge clk) rd_addr_q <= bus.rd_channel;

    int n_vec  = 0;
    int n_fail = 0;

    // Table model: each channel keeps its latest and previous write with the edge at which
    // the write lands; an entry counts only if it landed after the most recent reset edge.
    int         m_rst_edge = 0;
    int         m_new_edge [16];
    int         m_old_edge [16];
    logic [9:0] m_new      [16];
    logic [9:0] m_old      [16];
    int         cur_ch     = -1;
    int         disc_left  = 0;
    bit         live       = 1'b0;
    logic       prev_done  = 1'b0;
    int         done_cnt   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.new_sample = 1'b0;
        repeat (n) begin
            tick();
            m_rst_edge = cyc;
        end
        rst    = 1'b0;
        cur_ch = -1;
        live   = 1'b1;
    endtask

    task automatic start_scan(input logic [15:0] mask);
        bus.channel_mask = mask;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 16'(bus.busy), 16'd1);
        check("err_cleared_by_start", 16'(bus.timeout_err), 16'd0);
    endtask

    task automatic begin_channel(input int ch);
        check("channel", 16'(bus.channel), 16'(ch));
        cur_ch    = ch;
        disc_left = Discard;
    endtask

    // One AVR strobe; the model decides from the discard rule whether it is kept.
    task automatic send(input logic [3:0] ch, input logic [9:0] val);
        bus.new_sample     = 1'b1;
        bus.sample_channel = ch;
        bus.sample         = val;
        if (int'(ch) == cur_ch) begin
            if (disc_left > 0) begin
                disc_left--;
            end else begin
                // Captured on the coming edge, written one edge later.
                m_old[ch]      = m_new[ch];
                m_old_edge[ch] = m_new_edge[ch];
                m_new[ch]      = val;
                m_new_edge[ch] = cyc + 2;
                cur_ch         = -1;
            end
        end
        tick();
        bus.new_sample = 1'b0;
    endtask

    task automatic read_check(input logic [3:0] ch, input logic ev, input logic [9:0] ed);
        bus.rd_channel = ch;
        tick();
        check("rd_valid_lit", 16'(bus.rd_valid), 16'(ev));
        if (ev) check("rd_sample_lit", 16'(bus.rd_sample), 16'(ed));
    endtask

    always @(negedge clk) begin : cmp
        logic       ev;
        logic [9:0] ed;
        int         a;
        if (live) begin
            a  = int'(rd_addr_q);
            ev = 1'b0;
            ed = 10'd0;
            if (cyc == m_rst_edge) begin
                check("rd_valid_reset", 16'(bus.rd_valid), 16'd0);
                check("rd_sample_reset", 16'(bus.rd_sample), 16'd0);
            end else begin
                if (m_new_edge[a] > m_rst_edge && m_new_edge[a] < cyc) begin
                    ev = 1'b1;
                    ed = m_new[a];
                end else if (m_old_edge[a] > m_rst_edge) begin
                    ev = 1'b1;
                    ed = m_old[a];
                end
                check("rd_valid_model", 16'(bus.rd_valid), 16'(ev));
                if (ev) check("rd_sample_model", 16'(bus.rd_sample), 16'(ed));
            end
            if (bus.scan_done) begin
                check("scan_done_width", 16'(prev_done), 16'd0);
                done_cnt++;
            end
            prev_done = bus.scan_done;
        end
    end

    initial begin
        int d0;
        bus.channel_mask   = '0;
        bus.start          = 1'b0;
        bus.continuous     = 1'b0;
        bus.new_sample     = 1'b0;
        bus.sample         = '0;
        bus.sample_channel = '0;
        bus.rd_channel     = '0;
        for (int i = 0; i < 16; i++) begin
            m_new_edge[i] = -1;
            m_old_edge[i] = -1;
            m_new[i]      = '0;
            m_old[i]      = '0;
        end

        do_reset(2);
        check("reset_channel", 16'(bus.channel), 16'd0);
        check("reset_busy", 16'(bus.busy), 16'd0);
        check("reset_scan_done", 16'(bus.scan_done), 16'd0);
        check("reset_timeout_err", 16'(bus.timeout_err), 16'd0);
        check("reset_rd_sample", 16'(bus.rd_sample), 16'd0);
        check("reset_rd_valid", 16'(bus.rd_valid), 16'd0);

        // Two-channel scan, first matching strobe of each channel dropped.
        d0 = done_cnt;
        start_scan(16'h0005);
        tick();
        begin_channel(0);
        send(4'd0, 10'h0AA);
        send(4'd0, 10'h155);
        tick();
        tick();
        begin_channel(2);
        send(4'd2, 10'h111);
        send(4'd2, 10'h2AA);
        tick();
        tick();
        check("t1_scan_done", 16'(bus.scan_done), 16'd1);
        check("t1_busy_low", 16'(bus.busy), 16'd0);
        tick();
        check("t1_scan_done_gone", 16'(bus.scan_done), 16'd0);
        read_check(4'd0, 1'b1, 10'h155);
        read_check(4'd2, 1'b1, 10'h2AA);
        read_check(4'd1, 1'b0, 10'h000);
        check("t1_done_count", 16'(done_cnt - d0), 16'd1);

        // Wrap-around in continuous mode: 0, 15, 0, 15.
        d0             = done_cnt;
        bus.continuous = 1'b1;
        start_scan(16'h8001);
        tick();
        begin_channel(0);
        send(4'd0, 10'h001);
        send(4'd0, 10'h011);
        tick();
        tick();
        begin_channel(15);
        send(4'd15, 10'h002);
        send(4'd15, 10'h3C3);
        tick();
        tick();
        check("t2_scan_done", 16'(bus.scan_done), 16'd1);
        check("t2_busy_cont", 16'(bus.busy), 16'd1);
        tick();
        begin_channel(0);
        send(4'd0, 10'h003);
        send(4'd0, 10'h022);
        tick();
        tick();
        begin_channel(15);
        send(4'd15, 10'h004);
        send(4'd15, 10'h3C4);
        bus.continuous = 1'b0;
        tick();
        tick();
        check("t2_scan_done_2", 16'(bus.scan_done), 16'd1);
        check("t2_busy_low", 16'(bus.busy), 16'd0);
        tick();
        check("t2_done_count", 16'(done_cnt - d0), 16'd2);
        read_check(4'd0, 1'b1, 10'h022);
        read_check(4'd15, 1'b1, 10'h3C4);

        // Stale strobes tagged ch1 while on ch3; a start while busy must not relatch.
        d0 = done_cnt;
        start_scan(16'h0008);
        tick();
        begin_channel(3);
        bus.channel_mask = 16'hFFFF;
        bus.start        = 1'b1;
        send(4'd1, 10'h3FF);
        bus.start = 1'b0;
        send(4'd1, 10'h3FE);
        send(4'd3, 10'h001);
        send(4'd1, 10'h3FD);
        send(4'd3, 10'h123);
        tick();
        tick();
        check("t3_scan_done", 16'(bus.scan_done), 16'd1);
        check("t3_busy_low", 16'(bus.busy), 16'd0);
        tick();
        bus.channel_mask = 16'h0000;
        read_check(4'd1, 1'b0, 10'h000);
        read_check(4'd3, 1'b1, 10'h123);
        check("t3_done_count", 16'(done_cnt - d0), 16'd1);

        // Empty mask: pulse two edges after start, no writes.
        d0 = done_cnt;
        start_scan(16'h0000);
        tick();
        check("t5_scan_done", 16'(bus.scan_done), 16'd1);
        check("t5_busy_low", 16'(bus.busy), 16'd0);
        tick();
        check("t5_scan_done_gone", 16'(bus.scan_done), 16'd0);
        check("t5_done_count", 16'(done_cnt - d0), 16'd1);

        // Reset in the middle of WAIT.
        start_scan(16'h0010);
        tick();
        begin_channel(4);
        send(4'd4, 10'h050);
        do_reset(1);
        check("t6_busy", 16'(bus.busy), 16'd0);
        check("t6_channel", 16'(bus.channel), 16'd0);
        check("t6_scan_done", 16'(bus.scan_done), 16'd0);
        for (int i = 0; i < 16; i++) read_check(4'(i), 1'b0, 10'h000);

        // Timeout on ch0, then ch1 serviced normally.
        start_scan(16'h0003);
        tick();
        begin_channel(0);
        repeat (Timeout - 1) tick();
        check("t4_err_not_yet", 16'(bus.timeout_err), 16'd0);
        check("t4_still_ch0", 16'(bus.channel), 16'd0);
        tick();
        check("t4_err_set", 16'(bus.timeout_err), 16'd1);
        check("t4_busy", 16'(bus.busy), 16'd1);
        tick();
        begin_channel(1);
        send(4'd1, 10'h005);
        send(4'd1, 10'h0AB);
        tick();
        tick();
        check("t4_scan_done", 16'(bus.scan_done), 16'd1);
        check("t4_err_sticky", 16'(bus.timeout_err), 16'd1);
        check("t4_busy_low", 16'(bus.busy), 16'd0);
        tick();
        read_check(4'd0, 1'b0, 10'h000);
        read_check(4'd1, 1'b1, 10'h0AB);

        // Kept sample on the expiry cycle wins over the timeout.
        start_scan(16'h0002);
        tick();
        begin_channel(1);
        send(4'd1, 10'h007);
        repeat (Timeout - 2) tick();
        send(4'd1, 10'h0F0);
        tick();
        tick();
        check("t4b_scan_done", 16'(bus.scan_done), 16'd1);
        check("t4b_no_err", 16'(bus.timeout_err), 16'd0);
        tick();
        read_check(4'd1, 1'b1, 10'h0F0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
